// File: rtl/inst_encoder_loader.sv
// Instruction encoder and instruction-memory loader.
// Packs one decoded-form command per valid/ready handshake into an RV32 word,
// range-checks the immediate, and writes accepted words sequentially into
// instruction memory over an ack handshake. A HALT command ends loading.
module inst_encoder_loader #(
    parameter int unsigned       ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              err,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W-2:0] count
);

    localparam logic [2:0] ClsLoad   = 3'b000;
    localparam logic [2:0] ClsOpImm  = 3'b001;
    localparam logic [2:0] ClsStore  = 3'b010;
    localparam logic [2:0] ClsOp     = 3'b011;
    localparam logic [2:0] ClsJal    = 3'b100;
    localparam logic [2:0] ClsJalr   = 3'b101;
    localparam logic [2:0] ClsBranch = 3'b110;
    localparam logic [2:0] ClsHalt   = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StHalted
    } state_e;

    state_e      state;
    logic        halt_pending;
    logic [31:0] enc_word;
    logic        imm_ok;
    logic        imm_i_ok;
    logic        imm_b_ok;
    logic        imm_j_ok;

    // An immediate fits a field when every bit above the field's sign bit matches it.
    assign imm_i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign imm_b_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign imm_j_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

    // Pack the command into its RV32 format and select the matching range rule.
    always_comb begin
        enc_word = '0;
        imm_ok   = 1'b1;
        unique case (in_class)
            ClsLoad: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
                imm_ok   = imm_i_ok;
            end
            ClsOpImm: begin
                // Shift-immediate forms carry funct7 in imm[11:5], so no special case.
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                imm_ok   = imm_i_ok;
            end
            ClsJalr: begin
                enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
                imm_ok   = imm_i_ok;
            end
            ClsOp: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            end
            ClsStore: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
                imm_ok   = imm_i_ok;
            end
            ClsBranch: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
                imm_ok   = imm_b_ok;
            end
            ClsJal: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, 7'b1101111};
                imm_ok   = imm_j_ok;
            end
            ClsHalt: begin
                enc_word = 32'h0000_007F;
            end
            default: ;
        endcase
    end

    // Load FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            halt_pending <= 1'b0;
            in_ready     <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= '0;
            err          <= 1'b0;
            done         <= 1'b0;
            wrapped      <= 1'b0;
            count        <= '0;
        end else begin
            err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        if (imm_ok) begin
                            imem_wdata   <= enc_word;
                            halt_pending <= (in_class == ClsHalt);
                            imem_we      <= 1'b1;
                            in_ready     <= 1'b0;
                            state        <= StWrite;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (imem_ack) begin
                        imem_we   <= 1'b0;
                        imem_addr <= imem_addr + ADDR_W'(4);
                        count     <= count + (ADDR_W-1)'(1);
                        // Last word slot in the space: this increment rolls over to 0.
                        if (&imem_addr[ADDR_W-1:2]) begin
                            wrapped <= 1'b1;
                        end
                        if (halt_pending) begin
                            done  <= 1'b1;
                            state <= StHalted;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= StIdle;
                        end
                    end
                end
                StHalted: ;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader: directed cases plus randomized
// commands checked against an arithmetic reference model of encoding, range
// checking and address/count bookkeeping.
module tb_inst_encoder_loader;

    localparam int unsigned AW         = 4;
    localparam int          ADDR_SPAN  = 1 << AW;
    localparam int          COUNT_SPAN = 1 << (AW - 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_class = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_ack = 1'b0;
    logic          err;
    logic          done;
    logic          wrapped;
    logic [AW-2:0] count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference bookkeeping
    int exp_addr    = 0;
    int exp_count   = 0;
    bit exp_wrapped = 1'b0;
    bit exp_done    = 1'b0;

    inst_encoder_loader #(
        .ADDR_W    (AW),
        .BASE_ADDR ('0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ack   (imem_ack),
        .err        (err),
        .done       (done),
        .wrapped    (wrapped),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Word built by shifting each field to its bit position.
    function automatic logic [31:0] ref_word(input logic [2:0] c, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [31:0] imm);
        logic [31:0] r, s1, s2, fn3, fn7;
        r   = 32'(rd);
        s1  = 32'(rs1);
        s2  = 32'(rs2);
        fn3 = 32'(f3);
        fn7 = 32'(f7);
        case (c)
            3'd0: return ((imm & 32'hFFF) << 20) | (s1 << 15) | (fn3 << 12) | (r << 7) | 32'h03;
            3'd1: return ((imm & 32'hFFF) << 20) | (s1 << 15) | (fn3 << 12) | (r << 7) | 32'h13;
            3'd5: return ((imm & 32'hFFF) << 20) | (s1 << 15) | (r << 7) | 32'h67;
            3'd3: return (fn7 << 25) | (s2 << 20) | (s1 << 15) | (fn3 << 12) | (r << 7) | 32'h33;
            3'd2: return (((imm >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (fn3 << 12)
                         | ((imm & 32'h1F) << 7) | 32'h23;
            3'd6: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                         | (s2 << 20) | (s1 << 15) | (fn3 << 12)
                         | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            3'd4: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                         | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                         | (r << 7) | 32'h6F;
            default: return 32'h0000_007F;
        endcase
    endfunction

    // Range rule expressed as signed numeric bounds.
    function automatic bit ref_ok(input logic [2:0] c, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (c)
            3'd0, 3'd1, 3'd2, 3'd5: return (s >= -2048) && (s <= 2047);
            3'd6: return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
            3'd4: return (s >= -(1 << 20)) && (s < (1 << 20)) && (imm[0] == 1'b0);
            default: return 1'b1;
        endcase
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_we"}, imem_we, 0);
        check({tag, "_addr"}, imem_addr, 0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wrapped"}, wrapped, 0);
        check({tag, "_count"}, count, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_addr    = 0;
        exp_count   = 0;
        exp_wrapped = 1'b0;
        exp_done    = 1'b0;
        check_reset_state(tag);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic send_cmd(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm, input int ack_dly,
                            input logic [31:0] golden, input bit use_golden);
        logic [31:0] w;
        bit          ok;
        int          old_addr;
        w  = use_golden ? golden : ref_word(c, rd, rs1, rs2, f3, f7, imm);
        ok = ref_ok(c, imm);
        check("ready_before_cmd", in_ready, 1);
        in_valid  = 1'b1;
        in_class  = c;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_imm   = $urandom;
        in_class = 3'($urandom);
        if (!ok) begin
            check("err_pulse", err, 1);
            check("err_no_we", imem_we, 0);
            check("err_ready", in_ready, 1);
            check("err_addr", imem_addr, 64'(exp_addr));
            check("err_count", count, 64'(exp_count));
            @(posedge clk);
            @(negedge clk);
            check("err_one_cycle", err, 0);
            check("err_no_we_later", imem_we, 0);
        end else begin
            check("write_we", imem_we, 1);
            check("write_ready_low", in_ready, 0);
            check("write_addr", imem_addr, 64'(exp_addr));
            check("write_data", imem_wdata, w);
            check("write_no_err", err, 0);
            for (int d = 0; d < ack_dly; d++) begin
                @(posedge clk);
                @(negedge clk);
                check("hold_we", imem_we, 1);
                check("hold_ready", in_ready, 0);
                check("hold_addr", imem_addr, 64'(exp_addr));
                check("hold_data", imem_wdata, w);
            end
            imem_ack = 1'b1;
            @(posedge clk);
            @(negedge clk);
            imem_ack = 1'b0;
            old_addr  = exp_addr;
            exp_addr  = (exp_addr + 4) % ADDR_SPAN;
            exp_count = (exp_count + 1) % COUNT_SPAN;
            if (old_addr == ADDR_SPAN - 4) exp_wrapped = 1'b1;
            if (c == 3'b111) exp_done = 1'b1;
            check("ack_we_low", imem_we, 0);
            check("ack_addr", imem_addr, 64'(exp_addr));
            check("ack_count", count, 64'(exp_count));
            check("ack_wrapped", wrapped, 64'(exp_wrapped));
            check("ack_done", done, 64'(exp_done));
            check("ack_ready", in_ready, 64'(!exp_done));
        end
    endtask

    function automatic logic [31:0] rand_imm();
        int kind;
        int edges[13] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                          1048574, 1048576, -1048576, -1048578, 3};
        kind = $urandom_range(0, 4);
        case (kind)
            0: return 32'($signed($urandom_range(0, 4095)) - 2048);
            1: return 32'($signed($urandom_range(0, 8191)) - 4096);
            2: return 32'($signed($urandom_range(0, 2097151)) - 1048576);
            3: return $urandom;
            default: return 32'(edges[$urandom_range(0, 12)]);
        endcase
    endfunction

    initial begin
        do_reset("reset0");

        // OP with immediate ack, then throughput: ready again 2 cycles after handshake
        send_cmd(3'b011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 0, 32'h002081B3, 1'b1);

        do_reset("reset1");
        send_cmd(3'b001, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1, 32'hFFF00293, 1'b1);
        send_cmd(3'b010, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 0, 32'h0020A423, 1'b1);
        // Branch with ack held off for 3 cycles
        send_cmd(3'b110, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 3, 32'hFE208EE3, 1'b1);
        // Range-check rejects
        send_cmd(3'b001, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 32'h0, 1'b0);
        send_cmd(3'b110, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 0, 32'h0, 1'b0);

        // Address wrap over a 16-byte space
        do_reset("reset2");
        for (int i = 0; i < 5; i++) begin
            send_cmd(3'b011, 5'(i + 1), 5'(i), 5'(i + 2), 3'(i), 7'h20, 32'd0, i % 2, 32'h0, 1'b0);
        end

        // Reset during a pending write drops it
        send_cmd(3'b011, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 0, 32'h0, 1'b0);
        in_valid = 1'b1;
        in_class = 3'b011;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("midwrite_we", imem_we, 1);
        do_reset("reset_midwrite");

        // Randomized commands against the model
        for (int i = 0; i < 80; i++) begin
            send_cmd(3'($urandom_range(0, 6)), 5'($urandom), 5'($urandom), 5'($urandom),
                     3'($urandom), 7'($urandom), rand_imm(), $urandom_range(0, 3),
                     32'h0, 1'b0);
        end

        // HALT, then further commands must be ignored
        send_cmd(3'b111, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'h1234_5678, 2, 32'h0000007F, 1'b1);
        in_valid = 1'b1;
        in_class = 3'b011;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("halted_no_we", imem_we, 0);
            check("halted_ready", in_ready, 0);
            check("halted_done", done, 1);
            check("halted_addr", imem_addr, 64'(exp_addr));
        end
        in_valid = 1'b0;
        do_reset("reset_after_halt");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
